iob2axi: RTL and testbench
==========================

IOB2AXI -- requirements
Module: iob2axi
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: byte address width of both buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of both buses; STRB_WIDTH = DATA_WIDTH/8, derived.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 1: width of AXI ID fields; all issued IDs are 0.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- iob_avalid_i  in  1  IOb request valid
- iob_addr_i  in  ADDR_WIDTH  request byte address
- iob_wdata_i  in  DATA_WIDTH  write data
- iob_wstrb_i  in  STRB_WIDTH  byte enables; nonzero = write, zero = read
- iob_ready_o  out  1  request accepted this cycle when high with iob_avalid_i
- iob_rvalid_o  out  1  one-cycle read-data strobe
- iob_rdata_o  out  DATA_WIDTH  read data, valid with iob_rvalid_o
- AW channel: m_axi_awid/awaddr/awvalid out, m_axi_awready in.
- AW/AR constants: awlen/arlen 8'd0, awsize/arsize log2(STRB_WIDTH), awburst/arburst 2'b01, awlock/arlock 0, awcache/arcache 4'b0011, awprot/arprot 3'b000.
- W channel: m_axi_wdata/wstrb/wlast/wvalid out (wlast = wvalid), m_axi_wready in.
- B channel: m_axi_bid/bresp/bvalid in, m_axi_bready out.
- AR channel: m_axi_arid/araddr/arvalid out, m_axi_arready in.
- R channel: m_axi_rid/rdata/rresp/rlast/rvalid in, m_axi_rready out.
Function
REQ-005 SHALL implement states IDLE, WRITE, WRESP, READ, RDATA; only one transaction outstanding.
REQ-006 iob_ready_o SHALL equal (state==IDLE), combinationally.
REQ-007 On accept in IDLE, SHALL register addr, wdata, wstrb, then go to WRITE if |wstrb, else READ.
REQ-008 WRITE: awvalid and wvalid SHALL assert the cycle after accept; each SHALL deassert independently on its own handshake; go to WRESP when both are done, including same-cycle completion.
REQ-009 WRESP: bready=1; on bvalid go to IDLE; no iob_rvalid_o for writes.
REQ-010 READ: arvalid=1 until arready, then RDATA.
REQ-011 RDATA: rready=1; on rvalid, register rdata into iob_rdata_o, pulse iob_rvalid_o one cycle later, go to IDLE.
REQ-012 Minimum latencies: accept-to-awvalid 1 cycle; rvalid-to-iob_rvalid_o 1 cycle; ready state: next request may be accepted the cycle after B or R handshake.
REQ-013 AXI valids SHALL hold with stable payload until handshake; bid, rid, rlast are ignored.
Reset
REQ-014 On rst: state IDLE; all AXI valids 0; bready, rready 0; iob_rvalid_o 0; iob_rdata_o 0; registered addr/data/strb 0.
REQ-015 Reset mid-transaction SHALL abandon it immediately without completing a handshake.
Configuration
REQ-016 With IOB2AXI_ERR_EN defined, SHALL add port err_o (out, 1): sticky flag, set the cycle after any bresp/rresp != 2'b00 handshake, cleared only by rst.
REQ-017 Without IOB2AXI_ERR_EN, err_o SHALL be absent and response codes ignored.
Structure
REQ-018 SHALL place state encodings and AXI constant values (burst INCR, cache, prot, OKAY) in shared package iob2axi_pkg.
REQ-019 SHALL build all 1-bit and vector registers from existing iob_reg_re; no other sub-module.
Verification
REQ-020 Write: avalid, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF; awready/wready same cycle, bvalid 2 cycles later -> one AW beat, len 0, size 2, iob_ready_o low until the cycle after B.
REQ-021 Read: addr 0x200, wstrb 0; arready immediately, rvalid with 0xCAFEF00D after 3 cycles -> iob_rvalid_o one cycle later with 0xCAFEF00D, exactly once.
REQ-022 Split write handshake: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds, B is awaited only after AW completes.
REQ-023 Back-to-back write then read, with the avalid held -> read accepted the cycle after bvalid; no overlap on AW and AR.
REQ-024 rst asserted during RDATA -> all outputs at reset values next edge; no iob_rvalid_o.
REQ-025 With IOB2AXI_ERR_EN: bresp 2'b10 -> err_o set and held through later OKAY transactions until rst.

Source files
------------

// File: rtl/iob2axi_pkg.sv
// iob2axi_pkg -- shared definitions for the IOb to AXI4 bridge.
//   state_t      : bridge FSM states
//   AXI_*        : fixed AXI4 attribute values driven on AW/AR
//   axi_size()   : AxSIZE encoding for a given strobe width
package iob2axi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      WRESP = 3'd2,
      READ  = 3'd3,
      RDATA = 3'd4
   } state_t;

   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic       AXI_LOCK_NORM  = 1'b0;
   localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
   localparam logic [2:0] AXI_PROT_DFLT  = 3'b000;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // log2 of the bytes per beat; strobe width is a power of two
   function automatic logic [2:0] axi_size(input int unsigned strb_w);
      logic [2:0] size;
      size = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if ((32'd1 << i) == strb_w) size = 3'(i);
      end
      return size;
   endfunction

endpackage

// File: rtl/iob_reg_re.sv
// iob_reg_re -- register with asynchronous reset, clock enable,
// synchronous reset and load enable.
//   clk_i   : clock
//   arst_i  : asynchronous active-high reset (loads RST_VAL)
//   cke_i   : clock enable
//   rst_i   : synchronous reset (loads RST_VAL)
//   en_i    : load enable
//   data_i  : next value
//   data_o  : registered value
module iob_reg_re #(
   parameter int unsigned            DATA_W  = 1,
   parameter logic [DATA_W-1:0]      RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         data_o <= RST_VAL;
      end else if (cke_i) begin
         if (rst_i) begin
            data_o <= RST_VAL;
         end else if (en_i) begin
            data_o <= data_i;
         end
      end
   end

endmodule

// File: rtl/iob2axi.sv
// iob2axi -- bridges single IOb requests onto AXI4 single-beat transfers,
// one transaction outstanding at a time.
//   clk, rst            : clock, asynchronous active-high reset
//   iob_*               : IOb slave side (nonzero wstrb = write, zero = read)
//   m_axi_aw*/w*/b*     : AXI4 master write channels
//   m_axi_ar*/r*        : AXI4 master read channels
//   err_o               : sticky error on non-OKAY response
//                         (present only when IOB2AXI_ERR_EN is defined)
module iob2axi
   import iob2axi_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH   = 32,
   parameter  int unsigned DATA_WIDTH   = 32,
   parameter  int unsigned AXI_ID_WIDTH = 1,
   localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst,
   // IOb
   input  logic                    iob_avalid_i,
   input  logic [ADDR_WIDTH-1:0]   iob_addr_i,
   input  logic [DATA_WIDTH-1:0]   iob_wdata_i,
   input  logic [STRB_WIDTH-1:0]   iob_wstrb_i,
   output logic                    iob_ready_o,
   output logic                    iob_rvalid_o,
   output logic [DATA_WIDTH-1:0]   iob_rdata_o,
   // AW
   output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   // W
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   // B
   input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   // AR
   output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   // R
   input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
`ifdef IOB2AXI_ERR_EN
   ,
   output logic                    err_o
`endif
);

   localparam logic [2:0] AXI_SIZE = axi_size(STRB_WIDTH);

   state_t                  state;
   state_t                  state_nxt;
   logic [2:0]              state_q;
   logic                    accept;
   logic                    awvalid_nxt;
   logic                    wvalid_nxt;
   logic                    arvalid_nxt;
   logic                    bready_nxt;
   logic                    rready_nxt;
   logic                    b_hs;
   logic                    r_hs;
   logic [ADDR_WIDTH-1:0]   addr_q;

   assign state       = state_t'(state_q);
   assign iob_ready_o = (state == IDLE);
   assign accept      = iob_avalid_i & iob_ready_o;
   assign b_hs        = m_axi_bvalid & m_axi_bready;
   assign r_hs        = m_axi_rvalid & m_axi_rready;

   // Fixed AXI attributes
   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = AXI_LEN_SINGLE;
   assign m_axi_awsize  = AXI_SIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = AXI_LOCK_NORM;
   assign m_axi_awcache = AXI_CACHE_MOD;
   assign m_axi_awprot  = AXI_PROT_DFLT;
   assign m_axi_wlast   = m_axi_wvalid;
   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = AXI_LEN_SINGLE;
   assign m_axi_arsize  = AXI_SIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = AXI_LOCK_NORM;
   assign m_axi_arcache = AXI_CACHE_MOD;
   assign m_axi_arprot  = AXI_PROT_DFLT;

   // FSM next-state and registered-output next values; every flop lives in
   // an iob_reg_re instance, so the FSM is split into this block plus registers.
   always_comb begin
      state_nxt   = state;
      awvalid_nxt = m_axi_awvalid & ~m_axi_awready;
      wvalid_nxt  = m_axi_wvalid & ~m_axi_wready;
      arvalid_nxt = m_axi_arvalid & ~m_axi_arready;
      case (state)
         IDLE: begin
            if (iob_avalid_i) begin
               if (|iob_wstrb_i) begin
                  state_nxt   = WRITE;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = READ;
                  arvalid_nxt = 1'b1;
               end
            end
         end
         // AW and W retire independently; leave once neither is pending
         WRITE:   if (!awvalid_nxt && !wvalid_nxt) state_nxt = WRESP;
         WRESP:   if (m_axi_bvalid) state_nxt = IDLE;
         READ:    if (m_axi_arready) state_nxt = RDATA;
         RDATA:   if (m_axi_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      bready_nxt = (state_nxt == WRESP);
      rready_nxt = (state_nxt == RDATA);
   end

   iob_reg_re #(.DATA_W(3), .RST_VAL(IDLE)) state_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(state_nxt), .data_o(state_q));

   // Request capture
   iob_reg_re #(.DATA_W(ADDR_WIDTH)) addr_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(accept),
      .data_i(iob_addr_i), .data_o(addr_q));
   iob_reg_re #(.DATA_W(DATA_WIDTH)) wdata_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(accept),
      .data_i(iob_wdata_i), .data_o(m_axi_wdata));
   iob_reg_re #(.DATA_W(STRB_WIDTH)) wstrb_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(accept),
      .data_i(iob_wstrb_i), .data_o(m_axi_wstrb));

   // AXI handshake signals
   iob_reg_re #(.DATA_W(1)) awvalid_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(awvalid_nxt), .data_o(m_axi_awvalid));
   iob_reg_re #(.DATA_W(1)) wvalid_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(wvalid_nxt), .data_o(m_axi_wvalid));
   iob_reg_re #(.DATA_W(1)) bready_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(bready_nxt), .data_o(m_axi_bready));
   iob_reg_re #(.DATA_W(1)) arvalid_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(arvalid_nxt), .data_o(m_axi_arvalid));
   iob_reg_re #(.DATA_W(1)) rready_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(rready_nxt), .data_o(m_axi_rready));

   // Read return: data captured on the R handshake, strobe one cycle later
   iob_reg_re #(.DATA_W(1)) rvalid_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(1'b1),
      .data_i(r_hs), .data_o(iob_rvalid_o));
   iob_reg_re #(.DATA_W(DATA_WIDTH)) rdata_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(r_hs),
      .data_i(m_axi_rdata), .data_o(iob_rdata_o));

`ifdef IOB2AXI_ERR_EN
   logic err_set;
   logic unused_in;
   assign err_set = (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) ||
                    (r_hs && (m_axi_rresp != AXI_RESP_OKAY));
   // Sticky: only ever loads 1, cleared by reset alone
   iob_reg_re #(.DATA_W(1)) err_reg (
      .clk_i(clk), .arst_i(rst), .cke_i(1'b1), .rst_i(1'b0), .en_i(err_set),
      .data_i(1'b1), .data_o(err_o));
   assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
`else
   logic unused_in;
   assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_bresp,
                        m_axi_rresp};
`endif

endmodule

// File: tb/tb_iob2axi.sv
// tb_iob2axi -- directed self-checking bench for iob2axi with an AXI
// scoreboard. Define IOB2AXI_ERR_EN to also exercise the sticky error flag.
module tb_iob2axi;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned IW = 1;

   logic          clk;
   logic          rst;
   logic          iob_avalid_i;
   logic [AW-1:0] iob_addr_i;
   logic [DW-1:0] iob_wdata_i;
   logic [SW-1:0] iob_wstrb_i;
   logic          iob_ready_o;
   logic          iob_rvalid_o;
   logic [DW-1:0] iob_rdata_o;
   logic [IW-1:0] awid;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awlock;
   logic [3:0]    awcache;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready;
   logic [IW-1:0] bid;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [IW-1:0] arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [IW-1:0] rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;
`ifdef IOB2AXI_ERR_EN
   logic          err_o;
`endif

   iob2axi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i),
      .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
      .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
      .iob_rdata_o(iob_rdata_o),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
      .m_axi_awcache(awcache), .m_axi_awprot(awprot),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
      .m_axi_arcache(arcache), .m_axi_arprot(arprot),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
`ifdef IOB2AXI_ERR_EN
      , .err_o(err_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Scoreboard queues, filled when a request is driven
   logic [AW-1:0]    exp_aw_q[$];
   logic [SW+DW-1:0] exp_w_q[$];
   logic [AW-1:0]    exp_ar_q[$];
   logic [DW-1:0]    exp_rd_q[$];

   int aw_beats = 0;
   int w_beats  = 0;
   int ar_beats = 0;
   int rv_cnt   = 0;

   logic          p_aw_pend = 1'b0;
   logic          p_w_pend  = 1'b0;
   logic          p_ar_pend = 1'b0;
   logic [AW-1:0] p_awaddr;
   logic [AW-1:0] p_araddr;
   logic [SW+DW-1:0] p_w;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs at the falling edge: inputs seen here are what the next rising
   // edge samples, so valid&ready here is exactly a handshake.
   task automatic monitor();
      if (!rst) begin
         chk("aw_ar_overlap", {63'd0, awvalid & arvalid}, 64'd0);
         if (p_aw_pend) chk("awvalid_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
         if (p_w_pend)  chk("wvalid_hold", {wvalid, wstrb, wdata}, {1'b1, p_w});
         if (p_ar_pend) chk("arvalid_hold", {arvalid, araddr}, {1'b1, p_araddr});
      end
      if (awvalid && awready) begin
         aw_beats++;
         chk("aw_expected", exp_aw_q.size(), 1);
         if (exp_aw_q.size() > 0) begin
            chk("awaddr", awaddr, exp_aw_q.pop_front());
            chk("aw_attr", {awid, awlen, awsize, awburst, awlock, awcache, awprot},
                {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
         end
      end
      if (wvalid && wready) begin
         w_beats++;
         chk("w_expected", exp_w_q.size(), 1);
         if (exp_w_q.size() > 0) begin
            chk("wstrb_wdata", {wstrb, wdata}, exp_w_q.pop_front());
            chk("wlast", wlast, 1);
         end
      end
      if (arvalid && arready) begin
         ar_beats++;
         chk("ar_expected", exp_ar_q.size(), 1);
         if (exp_ar_q.size() > 0) begin
            chk("araddr", araddr, exp_ar_q.pop_front());
            chk("ar_attr", {arid, arlen, arsize, arburst, arlock, arcache, arprot},
                {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
         end
      end
      if (iob_rvalid_o) begin
         rv_cnt++;
         chk("rd_expected", exp_rd_q.size(), 1);
         if (exp_rd_q.size() > 0) chk("iob_rdata", iob_rdata_o, exp_rd_q.pop_front());
      end
      p_aw_pend = !rst && awvalid && !awready;
      p_w_pend  = !rst && wvalid && !wready;
      p_ar_pend = !rst && arvalid && !arready;
      p_awaddr  = awaddr;
      p_araddr  = araddr;
      p_w       = {wstrb, wdata};
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iob_avalid_i = 0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
      awready = 0; wready = 0; bid = '0; bresp = 2'b00; bvalid = 0;
      arready = 0; rid = '0; rdata = 32'hBAD0BAD0; rresp = 2'b00;
      rlast = 1'b1; rvalid = 0;

      // Reset state
      step; step;
      chk("rst_ready", iob_ready_o, 1);
      chk("rst_ctl", {awvalid, wvalid, arvalid, bready, rready, iob_rvalid_o}, 6'b0);
      chk("rst_rdata", iob_rdata_o, 0);
`ifdef IOB2AXI_ERR_EN
      chk("rst_err", err_o, 0);
`endif
      rst = 1'b0;
      step;

      // Single write, AW/W ready at once, B two cycles later
      iob_avalid_i = 1; iob_addr_i = 32'h100; iob_wdata_i = 32'hDEADBEEF;
      iob_wstrb_i = 4'hF; awready = 1; wready = 1;
      exp_aw_q.push_back(32'h100); exp_w_q.push_back({4'hF, 32'hDEADBEEF});
      step;
      iob_avalid_i = 0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
      chk("t1_ready_low", iob_ready_o, 0);
      chk("t1_aw_w_valid", {awvalid, wvalid}, 2'b11);
      step;
      awready = 0; wready = 0;
      chk("t1_wresp", {awvalid, wvalid, bready, iob_ready_o}, 4'b0010);
      step;
      chk("t1_wait_b", iob_ready_o, 0);
      bvalid = 1;
      step;
      bvalid = 0;
      chk("t1_idle", {iob_ready_o, bready, iob_rvalid_o}, 3'b100);
      chk("t1_aw_beats", aw_beats, 1);

      // Single read, AR ready at once, R three cycles later
      arready = 1; iob_avalid_i = 1; iob_addr_i = 32'h200;
      iob_wdata_i = 32'hFFFFFFFF; iob_wstrb_i = 4'h0;
      exp_ar_q.push_back(32'h200); exp_rd_q.push_back(32'hCAFEF00D);
      step;
      iob_avalid_i = 0; iob_addr_i = '0;
      chk("t2_ar", {arvalid, awvalid, wvalid, iob_ready_o}, 4'b1000);
      step;
      arready = 0;
      chk("t2_rdata_state", {arvalid, rready}, 2'b01);
      step; step;
      rvalid = 1; rdata = 32'hCAFEF00D;
      chk("t2_no_early_rvalid", iob_rvalid_o, 0);
      step;
      rvalid = 0; rdata = 32'hBAD0BAD0;
      chk("t2_rvalid_pulse", {iob_rvalid_o, iob_ready_o, rready}, 3'b110);
      chk("t2_rdata_out", iob_rdata_o, 32'hCAFEF00D);
      step;
      chk("t2_rvalid_drop", iob_rvalid_o, 0);
      step;
      chk("t2_rvalid_count", rv_cnt, 1);

      // Split write: W completes three cycles before AW, B offered early
      awready = 0; wready = 1; bvalid = 1;
      iob_avalid_i = 1; iob_addr_i = 32'h300; iob_wdata_i = 32'h11223344;
      iob_wstrb_i = 4'h3;
      exp_aw_q.push_back(32'h300); exp_w_q.push_back({4'h3, 32'h11223344});
      step;
      iob_avalid_i = 0;
      chk("t3_valids", {awvalid, wvalid}, 2'b11);
      step;
      wready = 0;
      chk("t3_w_done", {awvalid, wvalid, bready}, 3'b100);
      step;
      chk("t3_aw_hold1", {awvalid, wvalid, bready}, 3'b100);
      step;
      chk("t3_aw_hold2", {awvalid, wvalid, bready}, 3'b100);
      awready = 1;
      step;
      chk("t3_wresp", {awvalid, bready}, 2'b01);
      step;
      awready = 0; bvalid = 0;
      chk("t3_idle", iob_ready_o, 1);
      chk("t3_beats", {aw_beats, w_beats}, {32'd2, 32'd2});

      // Write then read back to back with avalid held
      awready = 1; wready = 1; arready = 1; bvalid = 0;
      iob_avalid_i = 1; iob_addr_i = 32'h400; iob_wdata_i = 32'hA5A5A5A5;
      iob_wstrb_i = 4'hF;
      exp_aw_q.push_back(32'h400); exp_w_q.push_back({4'hF, 32'hA5A5A5A5});
      step;
      iob_addr_i = 32'h500; iob_wstrb_i = 4'h0;
      exp_ar_q.push_back(32'h500); exp_rd_q.push_back(32'h13579BDF);
      chk("t4_write", {iob_ready_o, awvalid, arvalid}, 3'b010);
      step;
      bvalid = 1;
      chk("t4_wresp", iob_ready_o, 0);
      step;
      bvalid = 0;
      chk("t4_ready_after_b", {iob_ready_o, arvalid}, 2'b10);
      step;
      iob_avalid_i = 0;
      chk("t4_read", {iob_ready_o, arvalid, awvalid}, 3'b010);
      rvalid = 1; rdata = 32'h13579BDF;
      step;
      chk("t4_rready", rready, 1);
      step;
      rvalid = 0;
      chk("t4_rvalid", iob_rvalid_o, 1);
      step;
      chk("t4_counts", {rv_cnt, ar_beats}, {32'd2, 32'd2});

      // Reset while waiting for R
      arready = 1; iob_avalid_i = 1; iob_addr_i = 32'h600; iob_wstrb_i = 4'h0;
      exp_ar_q.push_back(32'h600);
      step;
      iob_avalid_i = 0;
      step;
      arready = 0;
      chk("t5_in_rdata", rready, 1);
      rst = 1; rvalid = 1; rdata = 32'h77777777;
      step;
      chk("t5_rst_ctl", {iob_ready_o, awvalid, wvalid, arvalid, bready, rready,
                         iob_rvalid_o}, 7'b1000000);
      chk("t5_rst_rdata", iob_rdata_o, 0);
      step;
      chk("t5_rst_norv", iob_rvalid_o, 0);
      rst = 0; rvalid = 0;
      step; step;
      chk("t5_rv_count", rv_cnt, 2);
      chk("t5_rdata_clear", iob_rdata_o, 0);

`ifdef IOB2AXI_ERR_EN
      // SLVERR on B sets the sticky flag; a later OKAY read keeps it
      awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
      iob_avalid_i = 1; iob_addr_i = 32'h700; iob_wdata_i = 32'h1;
      iob_wstrb_i = 4'h1;
      exp_aw_q.push_back(32'h700); exp_w_q.push_back({4'h1, 32'h1});
      step;
      iob_avalid_i = 0;
      step;
      chk("t6_err_before", err_o, 0);
      step;
      bvalid = 0; bresp = 2'b00;
      chk("t6_err_set", err_o, 1);
      arready = 1; rvalid = 1; rresp = 2'b00; rdata = 32'h2468ACE0;
      iob_avalid_i = 1; iob_addr_i = 32'h800; iob_wstrb_i = 4'h0;
      exp_ar_q.push_back(32'h800); exp_rd_q.push_back(32'h2468ACE0);
      step;
      iob_avalid_i = 0;
      step; step;
      rvalid = 0; arready = 0;
      step;
      chk("t6_err_held", err_o, 1);
      chk("t6_rv_count", rv_cnt, 3);
      rst = 1;
      step;
      chk("t6_err_clear", err_o, 0);
      rst = 0;
      step;
`endif

      chk("sb_drained", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() +
          exp_rd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
